// File: rtl/lsu_seq_if.sv
// lsu_seq_if: request/response and memory-port bundle for the load/store sequencer.
//   req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata : request from the control unit
//   done/fault/rdata                                           : completion back to the control unit
//   mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata   : memory port command
//   mem_rdata/mem_resp                                         : memory port response
// The slave modport is the sequencer's view; master is the view of its environment
// (control unit plus memory).
interface lsu_seq_if #(
    parameter int DATA_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              done;
    logic [1:0]        fault;
    logic [DATA_W-1:0] rdata;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [BYTES-1:0]  mem_byte_enable;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, done, fault, rdata,
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, done, fault, rdata,
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata
    );
endinterface

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer for the multicycle RV32I core.
// Takes one request at a time, drives the memory port with lane-aligned data and byte
// enables, splits bus-word-crossing accesses into two beats and returns sign/zero-extended
// load data with a one-cycle done pulse and a fault code
// (00 ok, 01 misaligned, 10 timeout, 11 illegal funct3).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - lsu_seq_if.slave: request, completion and memory-port signals
// Parameters:
//   DATA_W           - bus width, 32 or 64
//   ALLOW_MISALIGNED - 1 splits word-crossing accesses, 0 faults any misaligned access
//   TIMEOUT          - max cycles per beat waiting for mem_resp, 0 disables
module lsu_seq #(
    parameter int DATA_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int TIMEOUT          = 0
) (
    input logic      clk,
    input logic      rst,
    lsu_seq_if.slave bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int OFFW    = $clog2(BYTES);
    localparam int MW      = 2 * BYTES;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state;
    logic              req_ready_q;
    logic              done_q;
    logic [1:0]        fault_q;
    logic [DATA_W-1:0] rdata_q;
    logic [31:0]       mem_addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [BYTES-1:0]  mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              store_q;
    logic [2:0]        f3_q;
    logic [OFFW-1:0]   off_q;
    logic              split_q;
    logic [BYTES-1:0]  be_hi_q;
    logic [DATA_W-1:0] wdata_hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [31:0]       beat_cnt;

    assign bus.req_ready       = req_ready_q;
    assign bus.done            = done_q;
    assign bus.fault           = fault_q;
    assign bus.rdata           = rdata_q;
    assign bus.mem_address     = mem_addr_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_byte_enable = mem_be_q;
    assign bus.mem_wdata       = mem_wdata_q;

    // Request decode: only consumed on the accepting edge, so nothing here reaches
    // the memory port without going through a register first.
    logic [OFFW-1:0]     req_off;
    logic [3:0]          req_size;
    logic [MW-1:0]       size_mask;
    logic [2:0]          align_mask;
    logic                req_illegal;
    logic                req_misaligned;
    logic                req_split;
    logic [MW-1:0]       full_mask;
    logic [2*DATA_W-1:0] wide_wdata;

    always_comb begin
        req_off = bus.req_addr[OFFW-1:0];
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_size   = 4'd1;
                size_mask  = MW'(8'h01);
                align_mask = 3'b000;
            end
            2'b01: begin
                req_size   = 4'd2;
                size_mask  = MW'(8'h03);
                align_mask = 3'b001;
            end
            2'b10: begin
                req_size   = 4'd4;
                size_mask  = MW'(8'h0F);
                align_mask = 3'b011;
            end
            default: begin
                req_size   = 4'd8;
                size_mask  = MW'(8'hFF);
                align_mask = 3'b111;
            end
        endcase

        if (bus.req_store) begin
            req_illegal = bus.req_funct3[2] ||
                          (DATA_W == 32 && bus.req_funct3 == 3'b011);
        end else begin
            req_illegal = (bus.req_funct3 == 3'b111) ||
                          (DATA_W == 32 && (bus.req_funct3 == 3'b011 ||
                                            bus.req_funct3 == 3'b110));
        end

        req_misaligned = |(bus.req_addr[2:0] & align_mask);
        req_split      = (int'(req_off) + int'(req_size)) > BYTES;
        full_mask      = size_mask << req_off;
        wide_wdata     = {{DATA_W{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
    end

    // Load extraction works on the final beat's mem_rdata directly so the result can be
    // registered on the same edge that ends the access.
    logic [2*DATA_W-1:0] beat_pair;
    logic [DATA_W-1:0]   aligned;
    logic [DATA_W-1:0]   width_mask;
    logic [DATA_W-1:0]   load_value;
    logic                sign_bit;
    logic                timed_out;

    always_comb begin
        if (state == ACC1) begin
            beat_pair = {bus.mem_rdata, lo_q};
        end else begin
            beat_pair = {{DATA_W{1'b0}}, bus.mem_rdata};
        end
        aligned = DATA_W'(beat_pair >> {off_q, 3'b000});

        case (f3_q[1:0])
            2'b00: begin
                width_mask = DATA_W'(8'hFF);
                sign_bit   = aligned[7];
            end
            2'b01: begin
                width_mask = DATA_W'(16'hFFFF);
                sign_bit   = aligned[15];
            end
            2'b10: begin
                width_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit   = aligned[31];
            end
            default: begin
                width_mask = '1;
                sign_bit   = aligned[DATA_W-1];
            end
        endcase

        load_value = aligned & width_mask;
        if (!f3_q[2] && sign_bit) begin
            load_value = load_value | ~width_mask;
        end

        // A response in the last allowed cycle still counts as success.
        timed_out = (TIMEOUT > 0) && (beat_cnt == 32'(TO_LAST)) && !bus.mem_resp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            fault_q     <= 2'b00;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            store_q     <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= '0;
            split_q     <= 1'b0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
            lo_q        <= '0;
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q     <= bus.req_store;
                        f3_q        <= bus.req_funct3;
                        off_q       <= req_off;
                        split_q     <= req_split;
                        be_hi_q     <= full_mask[MW-1:BYTES];
                        wdata_hi_q  <= wide_wdata[2*DATA_W-1:DATA_W];
                        beat_cnt    <= '0;
                        req_ready_q <= 1'b0;
                        if (req_illegal) begin
                            state   <= RESP;
                            done_q  <= 1'b1;
                            fault_q <= 2'b11;
                            rdata_q <= '0;
                        end else if (req_misaligned && !ALLOW_MISALIGNED) begin
                            state   <= RESP;
                            done_q  <= 1'b1;
                            fault_q <= 2'b01;
                            rdata_q <= '0;
                        end else begin
                            state       <= ACC0;
                            mem_read_q  <= !bus.req_store;
                            mem_write_q <= bus.req_store;
                            mem_addr_q  <= {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
                            mem_be_q    <= full_mask[BYTES-1:0];
                            mem_wdata_q <= bus.req_store ? wide_wdata[DATA_W-1:0] : '0;
                        end
                    end
                end

                ACC0, ACC1: begin
                    if (bus.mem_resp) begin
                        if (state == ACC0 && split_q) begin
                            // Second beat: next bus word, wrapping at the top of memory.
                            lo_q        <= bus.mem_rdata;
                            state       <= ACC1;
                            mem_addr_q  <= mem_addr_q + 32'(BYTES);
                            mem_be_q    <= be_hi_q;
                            mem_wdata_q <= wdata_hi_q;
                            beat_cnt    <= '0;
                        end else begin
                            state       <= RESP;
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 1'b0;
                            mem_be_q    <= '0;
                            mem_wdata_q <= '0;
                            done_q      <= 1'b1;
                            fault_q     <= 2'b00;
                            rdata_q     <= store_q ? '0 : load_value;
                        end
                    end else if (timed_out) begin
                        // A first store beat that already landed is left in memory.
                        state       <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                        fault_q     <= 2'b10;
                        rdata_q     <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    done_q      <= 1'b0;
                    fault_q     <= 2'b00;
                    rdata_q     <= '0;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: self-checking bench for lsu_seq.
// Two instances share clock and reset: dut (32-bit, misaligned splitting, TIMEOUT=8) and
// dut_strict (32-bit, misaligned accesses fault, no timeout). The bench plays both the
// control unit and the memory. Expected completions are queued when a request is driven
// and popped when done is observed.
module tb_lsu_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [1:0]  fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    lsu_seq_if #(.DATA_W(32)) bus ();
    lsu_seq_if #(.DATA_W(32)) bus_b ();

    lsu_seq #(.DATA_W(32), .ALLOW_MISALIGNED(1'b1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    lsu_seq #(.DATA_W(32), .ALLOW_MISALIGNED(1'b0), .TIMEOUT(0)) dut_strict (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one accepting edge, then withdraw it.
    task automatic start_req(input logic store, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_store  = store;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    // An empty scoreboard yields X so the following comparison cannot match.
    task automatic pop_exp(output exp_t e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.fault !== 2'b00 || bus.rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got fault=%b rdata=%h want 00/0", bus.fault, bus.rdata); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes: got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_byte_enable !== 4'b0 || bus.mem_address !== 32'h0 || bus.mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_port: got be=%b addr=%h wdata=%h want 0", bus.mem_byte_enable, bus.mem_address, bus.mem_wdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_aligned_load();
        exp_t e;
        start_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        exp_q.push_back('{fault: 2'b00, rdata: 32'hDEAD_BEEF});
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h100 || bus.mem_byte_enable !== 4'b1111) begin failures++; $display("[TB] FAIL lw_beat: got rd=%b addr=%h be=%b want 1/100/1111", bus.mem_read, bus.mem_address, bus.mem_byte_enable); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL lw_busy: got req_ready=%b want 0", bus.req_ready); end
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL lw_done_t2: got %b want 1", bus.done); end
        pop_exp(e);
        checks++; if (bus.fault !== e.fault || bus.rdata !== e.rdata) begin failures++; $display("[TB] FAIL lw_result: got %b/%h want %b/%h", bus.fault, bus.rdata, e.fault, e.rdata); end
        checks++; if (bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL lw_strobe_drop: got %b want 0", bus.mem_read); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL lw_idle: got done=%b ready=%b want 0/1", bus.done, bus.req_ready); end
    endtask

    // Byte loads at every lane, signed and unsigned; expected value picked straight from the word.
    task automatic test_byte_loads();
        logic [31:0] word;
        logic [7:0]  b;
        logic [31:0] want;
        exp_t        e;
        word = 32'h80C1_7F01;
        for (int off = 0; off < 4; off++) begin
            for (int u = 0; u < 2; u++) begin
                start_req(1'b0, (u == 1) ? 3'b100 : 3'b000, 32'h0000_0040 + 32'(off), 32'h0);
                b    = 8'(word >> (8 * off));
                want = (u == 0 && b[7]) ? {24'hFF_FFFF, b} : {24'h0, b};
                exp_q.push_back('{fault: 2'b00, rdata: want});
                checks++; if (bus.mem_byte_enable !== 4'(1 << off) || bus.mem_address !== 32'h40) begin failures++; $display("[TB] FAIL byte_lane off=%0d: got be=%b addr=%h", off, bus.mem_byte_enable, bus.mem_address); end
                bus.mem_rdata = word;
                bus.mem_resp  = 1'b1;
                tick();
                bus.mem_resp  = 1'b0;
                pop_exp(e);
                checks++; if (bus.done !== 1'b1 || bus.rdata !== e.rdata || bus.fault !== e.fault) begin failures++; $display("[TB] FAIL byte_load off=%0d u=%0d: got done=%b %b/%h want 1 %b/%h", off, u, bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
                tick();
            end
        end
    endtask

    task automatic test_split_load();
        logic [2:0] f3s [2];
        exp_t e;
        f3s[0] = 3'b001;
        f3s[1] = 3'b101;
        for (int i = 0; i < 2; i++) begin
            start_req(1'b0, f3s[i], 32'h0000_0103, 32'h0);
            exp_q.push_back('{fault: 2'b00, rdata: (i == 0) ? 32'hFFFF_FFAA : 32'h0000_FFAA});
            checks++; if (bus.mem_address !== 32'h100 || bus.mem_byte_enable !== 4'b1000 || bus.mem_read !== 1'b1) begin failures++; $display("[TB] FAIL split_beat0: got addr=%h be=%b rd=%b", bus.mem_address, bus.mem_byte_enable, bus.mem_read); end
            bus.mem_rdata = 32'hAA00_0000;
            bus.mem_resp  = 1'b1;
            tick();
            bus.mem_rdata = 32'h0000_00FF;
            checks++; if (bus.mem_address !== 32'h104 || bus.mem_byte_enable !== 4'b0001 || bus.mem_read !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("[TB] FAIL split_beat1: got addr=%h be=%b rd=%b done=%b", bus.mem_address, bus.mem_byte_enable, bus.mem_read, bus.done); end
            tick();
            bus.mem_resp  = 1'b0;
            pop_exp(e);
            checks++; if (bus.done !== 1'b1 || bus.fault !== e.fault || bus.rdata !== e.rdata) begin failures++; $display("[TB] FAIL split_result f3=%b: got done=%b %b/%h want 1 %b/%h", f3s[i], bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
            tick();
        end
    endtask

    // Misaligned but inside one word: single beat.
    task automatic test_misaligned_single();
        exp_t e;
        start_req(1'b0, 3'b001, 32'h0000_0101, 32'h0);
        exp_q.push_back('{fault: 2'b00, rdata: 32'hFFFF_ABCD});
        checks++; if (bus.mem_address !== 32'h100 || bus.mem_byte_enable !== 4'b0110) begin failures++; $display("[TB] FAIL mis_single_beat: got addr=%h be=%b want 100/0110", bus.mem_address, bus.mem_byte_enable); end
        bus.mem_rdata = 32'h00AB_CD00;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        pop_exp(e);
        checks++; if (bus.done !== 1'b1 || bus.fault !== e.fault || bus.rdata !== e.rdata) begin failures++; $display("[TB] FAIL mis_single_result: got done=%b %b/%h want 1 %b/%h", bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
        tick();
    endtask

    task automatic test_split_store();
        exp_t e;
        start_req(1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344);
        exp_q.push_back('{fault: 2'b00, rdata: 32'h0});
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'hFFFF_FFFC || bus.mem_byte_enable !== 4'b1100 || bus.mem_wdata !== 32'h3344_0000) begin failures++; $display("[TB] FAIL sw_beat0: got wr=%b rd=%b addr=%h be=%b wdata=%h", bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_byte_enable, bus.mem_wdata); end
        bus.mem_resp = 1'b1;
        tick();
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h0 || bus.mem_byte_enable !== 4'b0011 || bus.mem_wdata !== 32'h0000_1122 || bus.done !== 1'b0) begin failures++; $display("[TB] FAIL sw_beat1: got wr=%b addr=%h be=%b wdata=%h done=%b", bus.mem_write, bus.mem_address, bus.mem_byte_enable, bus.mem_wdata, bus.done); end
        tick();
        bus.mem_resp = 1'b0;
        pop_exp(e);
        checks++; if (bus.done !== 1'b1 || bus.fault !== e.fault || bus.rdata !== e.rdata || bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL sw_done_t3: got done=%b %b/%h wr=%b want 1 %b/%h 0", bus.done, bus.fault, bus.rdata, bus.mem_write, e.fault, e.rdata); end
        tick();
    endtask

    task automatic test_illegal();
        logic [3:0] cases [5];
        exp_t e;
        cases[0] = 4'b0011;
        cases[1] = 4'b0110;
        cases[2] = 4'b0111;
        cases[3] = 4'b1100;
        cases[4] = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            start_req(cases[i][3], cases[i][2:0], 32'h0000_0200, 32'hFFFF_FFFF);
            exp_q.push_back('{fault: 2'b11, rdata: 32'h0});
            pop_exp(e);
            checks++; if (bus.done !== 1'b1 || bus.fault !== e.fault || bus.rdata !== e.rdata) begin failures++; $display("[TB] FAIL illegal st=%b f3=%b: got done=%b %b/%h want 1 %b/%h", cases[i][3], cases[i][2:0], bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
            checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin failures++; $display("[TB] FAIL illegal_strobe: got rd=%b wr=%b want 0/0", bus.mem_read, bus.mem_write); end
            tick();
        end
    endtask

    task automatic test_strict_misaligned();
        logic [31:0] addrs [3];
        logic [2:0]  f3s [3];
        exp_t e;
        addrs[0] = 32'h102; f3s[0] = 3'b010;
        addrs[1] = 32'h101; f3s[1] = 3'b001;
        addrs[2] = 32'h104; f3s[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            bus_b.req_store  = 1'b0;
            bus_b.req_funct3 = f3s[i];
            bus_b.req_addr   = addrs[i];
            bus_b.req_valid  = 1'b1;
            tick();
            bus_b.req_valid  = 1'b0;
            if (i < 2) begin
                exp_q.push_back('{fault: 2'b01, rdata: 32'h0});
                pop_exp(e);
                checks++; if (bus_b.done !== 1'b1 || bus_b.fault !== e.fault || bus_b.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL strict_mis addr=%h: got done=%b fault=%b rd=%b want 1 %b 0", addrs[i], bus_b.done, bus_b.fault, bus_b.mem_read, e.fault); end
            end else begin
                exp_q.push_back('{fault: 2'b00, rdata: 32'h1234_5678});
                checks++; if (bus_b.mem_read !== 1'b1 || bus_b.mem_address !== 32'h104) begin failures++; $display("[TB] FAIL strict_aligned_beat: got rd=%b addr=%h want 1/104", bus_b.mem_read, bus_b.mem_address); end
                bus_b.mem_rdata = 32'h1234_5678;
                bus_b.mem_resp  = 1'b1;
                tick();
                bus_b.mem_resp  = 1'b0;
                pop_exp(e);
                checks++; if (bus_b.done !== 1'b1 || bus_b.fault !== e.fault || bus_b.rdata !== e.rdata) begin failures++; $display("[TB] FAIL strict_aligned: got done=%b %b/%h want 1 %b/%h", bus_b.done, bus_b.fault, bus_b.rdata, e.fault, e.rdata); end
            end
            tick();
        end
    endtask

    // Strobe must stay up exactly 8 cycles; a response in the 8th cycle still succeeds.
    task automatic test_timeout();
        int   held;
        exp_t e;
        for (int resp_on = 0; resp_on < 2; resp_on++) begin
            start_req(1'b0, 3'b000, 32'h0000_0010, 32'h0);
            exp_q.push_back((resp_on == 1) ? '{fault: 2'b00, rdata: 32'hFFFF_FF80} : '{fault: 2'b10, rdata: 32'h0});
            held = 0;
            while (bus.mem_read === 1'b1 && held < 20) begin
                held++;
                if (resp_on == 1 && held == 8) begin
                    bus.mem_rdata = 32'h0000_0080;
                    bus.mem_resp  = 1'b1;
                end
                tick();
                bus.mem_resp = 1'b0;
            end
            checks++; if (held !== 8) begin failures++; $display("[TB] FAIL timeout_strobe_len resp=%0d: got %0d cycles want 8", resp_on, held); end
            pop_exp(e);
            checks++; if (bus.done !== 1'b1 || bus.fault !== e.fault || bus.rdata !== e.rdata) begin failures++; $display("[TB] FAIL timeout_result resp=%0d: got done=%b %b/%h want 1 %b/%h", resp_on, bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0200;
        bus.req_valid  = 1'b1;
        tick();
        exp_q.push_back('{fault: 2'b00, rdata: 32'hCAFE_0001});
        bus.mem_rdata = 32'hCAFE_0001;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        bus.req_addr  = 32'h0000_0204;
        pop_exp(e);
        checks++; if (bus.done !== 1'b1 || bus.rdata !== e.rdata || bus.fault !== e.fault) begin failures++; $display("[TB] FAIL b2b_first: got done=%b %b/%h want 1 %b/%h", bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_in_done: got %b want 0", bus.req_ready); end
        tick();
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap: got ready=%b rd=%b done=%b want 1/0/0", bus.req_ready, bus.mem_read, bus.done); end
        tick();
        bus.req_valid = 1'b0;
        exp_q.push_back('{fault: 2'b00, rdata: 32'hCAFE_0002});
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'h204) begin failures++; $display("[TB] FAIL b2b_second_beat: got rd=%b addr=%h want 1/204", bus.mem_read, bus.mem_address); end
        bus.mem_rdata = 32'hCAFE_0002;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        pop_exp(e);
        checks++; if (bus.done !== 1'b1 || bus.rdata !== e.rdata || bus.fault !== e.fault) begin failures++; $display("[TB] FAIL b2b_second: got done=%b %b/%h want 1 %b/%h", bus.done, bus.fault, bus.rdata, e.fault, e.rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 3'b001, 32'h0000_0103, 32'h0);
        bus.mem_rdata = 32'hAA00_0000;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        checks++; if (bus.mem_address !== 32'h104 || bus.mem_read !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_in_acc1: got addr=%h rd=%b want 104/1", bus.mem_address, bus.mem_read); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0 || bus.mem_byte_enable !== 4'b0) begin failures++; $display("[TB] FAIL rst_mid: got rd=%b ready=%b done=%b be=%b want 0/1/0/0", bus.mem_read, bus.req_ready, bus.done, bus.mem_byte_enable); end
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        checks++; if (bus.done !== 1'b0 || bus.mem_read !== 1'b0) begin failures++; $display("[TB] FAIL stray_resp: got done=%b rd=%b want 0/0", bus.done, bus.mem_read); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stray_resp_after: got done=%b ready=%b want 0/1", bus.done, bus.req_ready); end
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_rdata    = 32'h0;
        bus.mem_resp     = 1'b0;
        bus_b.req_valid  = 1'b0;
        bus_b.req_store  = 1'b0;
        bus_b.req_funct3 = 3'b000;
        bus_b.req_addr   = 32'h0;
        bus_b.req_wdata  = 32'h0;
        bus_b.mem_rdata  = 32'h0;
        bus_b.mem_resp   = 1'b0;

        test_reset();
        test_aligned_load();
        test_byte_loads();
        test_split_load();
        test_misaligned_single();
        test_split_store();
        test_illegal();
        test_strict_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/lsu_seq.md
# lsu_seq

Parametrised load/store sequencer for the multicycle RV32I core; the successor to the byte-enable logic in the control FSM's load and store states. It takes one memory request from the control unit and drives the memory port with the correct byte enables. It splits accesses that cross a bus-word boundary into two beats, then returns sign- or zero-extended load data. It flags misaligned, illegal-width and timed-out accesses instead of hanging.

## Interface
- DATA_W, 32: memory bus width; 32 or 64. BYTES = DATA_W/8, OFFW = log2(BYTES).
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses; 0 = any non-naturally-aligned access faults.
- TIMEOUT, 0: max cycles per beat waiting for mem_resp; 0 disables the timeout.
- clk  input  1  clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; accepted when req_ready=1.
- req_ready  output  1  high only in IDLE.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV load/store funct3 (lb/lh/lw/lbu/lhu/ld/lwu; sb/sh/sw/sd).
- req_addr  input  32  byte address.
- req_wdata  input  DATA_W  store data, right-aligned.
- done  output  1  one-cycle completion pulse.
- fault  output  2  valid with done: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- rdata  output  DATA_W  extended load data; valid with done; 0 for stores and faults.
- mem_address  output  32  bus-word-aligned address (low OFFW bits 0).
- mem_read, mem_write  output  1  held until mem_resp or timeout.
- mem_byte_enable  output  BYTES  lane mask.
- mem_wdata  output  DATA_W  lane-aligned store data.
- mem_rdata  input  DATA_W  read data, valid with mem_resp.
- mem_resp  input  1  beat complete.

## Operation
- States: IDLE, ACC0, ACC1, RESP. Reset values: state IDLE, req_ready 1, done 0, fault 00, rdata 0, mem_read/mem_write 0, mem_byte_enable 0, mem_address 0, mem_wdata 0.
- Request capture in IDLE with req_valid: latch op, funct3, addr, wdata. size = 1/2/4/8 bytes, off = addr[OFFW-1:0].
- Illegal funct3 goes straight to RESP with fault 11 and no memory access:
  - loads 011 and 110 when DATA_W=32; load 111 always;
  - stores 1xx always, and 011 when DATA_W=32.
- Misaligned access:
  - Misaligned means addr is not a multiple of size.
  - ALLOW_MISALIGNED=0: misaligned goes to RESP with fault 01, no access.
  - ALLOW_MISALIGNED=1: the access splits only if off+size > BYTES. A misaligned access that fits in one word is a single beat.
- Otherwise go to ACC0.
- Masks: full = ((1<<size)-1) << off, 2*BYTES wide. Beat0 uses the low BYTES bits, beat1 the high BYTES bits.
  - Store data: (wdata zero-extended to 2*DATA_W) << 8*off; low half to beat0, high half to beat1.
- ACC0: mem_address = addr & ~(BYTES-1); enables = low mask.
  - On mem_resp, capture mem_rdata into lo.
  - Next state is ACC1 if split, else RESP.
- ACC1: mem_address = ACC0 address + BYTES, modulo 2^32 (0xFFFFFFFC+4 wraps to 0x0). Enables = high mask. On mem_resp, capture into hi, go to RESP.
- Load result: ({hi,lo} >> 8*off) truncated to size. Sign-extend for lb/lh/lw(64-bit); zero-extend for lbu/lhu/lwu.
- Timeout (TIMEOUT>0):
  - The per-beat counter clears on entering ACC0/ACC1 and increments each cycle without mem_resp.
  - When the counter reaches TIMEOUT-1 without mem_resp, drop mem_read/mem_write and go to RESP with fault 10. A mem_resp arriving in that same cycle wins (no fault).
  - rdata is 0 on timeout. A split store may have written beat0 already; it is not rolled back.
- RESP: done=1 for one cycle, then IDLE. req_valid is ignored outside IDLE.
- Reset mid-operation: the next cycle is IDLE with all mem strobes 0. Any late mem_resp is ignored in IDLE.

## Timing
- Outputs are registered and decoded from state/latched request. Nothing combinational runs from req_* to mem_*.
- Request accepted at edge T. ACC0 strobes are visible in cycle T+1.
- Aligned access with mem_resp in first ACC cycle: done in cycle T+2. Each wait cycle adds 1.
- Split access, zero-wait: done at T+3.
- Pre-access fault (01/11): done at T+1, mem strobes never asserted.
- Timeout: strobe high exactly TIMEOUT cycles per beat, done the cycle after.
- Back-to-back requests: earliest next acceptance is the cycle after done.

## Test plan
- lw 0x100 (DATA_W=32), mem_rdata 0xDEADBEEF, mem_resp immediate -> address 0x100, enable 1111, done at T+2, rdata 0xDEADBEEF, fault 00.
- lh 0x103, ALLOW=1: beat0 returns 0xAA000000, beat1 returns 0x000000FF -> beat0 addr 0x100 en 1000, beat1 addr 0x104 en 0001, rdata 0xFFFFFFAA. lhu gives 0x0000FFAA.
- sw 0xFFFFFFFE, wdata 0x11223344:
  - beat0 addr 0xFFFFFFFC en 1100 wdata 0x33440000;
  - beat1 addr 0x00000000 en 0011 wdata 0x00001122;
  - done at T+3.
- ALLOW=0, lw 0x102 -> no mem_read, done T+1, fault 01. Load funct3 011 at DATA_W=32 -> fault 11.
- TIMEOUT=8, mem_resp held low on lb 0x10 -> mem_read high 8 cycles then 0, done with fault 10, rdata 0. Repeat with mem_resp on the 8th cycle -> fault 00.
- rst asserted during ACC1 of a split load -> next cycle mem_read 0, req_ready 1, done 0. A stray mem_resp in IDLE produces no done.
